// File: rtl/melody_sequencer_if.sv
// melody_sequencer_if: control, table-write and tone-output signals of the melody sequencer.
interface melody_sequencer_if #(
    parameter int DIV_W  = 32,
    parameter int DUR_W  = 8,
    parameter int ADDR_W = 5
);
    logic              tick;
    logic              start;
    logic              stop;
    logic              loop_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DIV_W-1:0]  wr_div;
    logic [DUR_W-1:0]  wr_dur;
    logic [DIV_W-1:0]  divisor;
    logic              note_valid;
    logic [ADDR_W-1:0] note_idx;
    logic              busy;
    logic              done;

    modport master (
        output tick, start, stop, loop_en, wr_en, wr_addr, wr_div, wr_dur,
        input  divisor, note_valid, note_idx, busy, done
    );
    modport slave (
        input  tick, start, stop, loop_en, wr_en, wr_addr, wr_div, wr_dur,
        output divisor, note_valid, note_idx, busy, done
    );
endinterface

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a table of (divisor, duration) entries on tempo ticks into a tone divider.
module melody_sequencer #(
    parameter int DIV_W     = 32,
    parameter int DUR_W     = 8,
    parameter int LEN       = 25,
    parameter int ADDR_W    = 5,
    parameter int GAP_TICKS = 1
) (
    input logic               clk,
    input logic               reset,
    melody_sequencer_if.slave bus
);
    localparam int GAP_W = $clog2(GAP_TICKS + 2);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    state_t            state, state_n;
    logic [DIV_W-1:0]  tbl_div [LEN];
    logic [DUR_W-1:0]  tbl_dur [LEN];
    logic [DIV_W-1:0]  divisor, div_n, cur_div;
    logic [DUR_W-1:0]  remaining, rem_n, cur_dur;
    logic [GAP_W-1:0]  gap_cnt, gap_n;
    logic [ADDR_W-1:0] note_idx, idx_n;
    logic              note_valid, valid_n, done, done_n, adv, fin;

    // The table is deliberately left out of reset so a melody survives it.
    always_ff @(posedge clk)
        if (bus.wr_en && 32'(bus.wr_addr) < LEN) begin
            tbl_div[bus.wr_addr] <= bus.wr_div;
            tbl_dur[bus.wr_addr] <= bus.wr_dur;
        end

    assign cur_div = tbl_div[note_idx];
    assign cur_dur = tbl_dur[note_idx];

    always_comb begin
        state_n = state;
        idx_n   = note_idx;
        div_n   = divisor;
        valid_n = note_valid;
        rem_n   = remaining;
        gap_n   = gap_cnt;
        done_n  = 1'b0;
        adv     = 1'b0;
        fin     = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                state_n = LOAD;
                idx_n   = '0;
            end
            LOAD: if (cur_dur == '0) fin = 1'b1;
            else begin
                state_n = PLAY;
                div_n   = cur_div;
                valid_n = cur_div != '0;
                rem_n   = cur_dur;
            end
            PLAY: if (bus.tick) begin
                rem_n = remaining - 1'b1;
                if (remaining == DUR_W'(1)) begin
                    if (GAP_TICKS > 0) begin
                        state_n = GAP;
                        gap_n   = GAP_W'(GAP_TICKS);
                        div_n   = '0;
                        valid_n = 1'b0;
                    end else adv = 1'b1;
                end
            end
            GAP: if (bus.tick) begin
                gap_n = gap_cnt - 1'b1;
                adv   = gap_cnt == GAP_W'(1);
            end
            default: state_n = IDLE;
        endcase
        if (adv) begin
            div_n   = '0;
            valid_n = 1'b0;
            if (32'(note_idx) < LEN - 1) begin
                idx_n   = note_idx + 1'b1;
                state_n = LOAD;
            end else fin = 1'b1;
        end
        // An end marker at entry 0 must never loop, or playback would spin on nothing.
        if (fin) begin
            div_n   = '0;
            valid_n = 1'b0;
            idx_n   = '0;
            state_n = (bus.loop_en && !(state == LOAD && note_idx == '0)) ? LOAD : IDLE;
            done_n  = state_n == IDLE;
        end
        if (bus.stop) begin
            state_n = IDLE;
            idx_n   = '0;
            div_n   = '0;
            valid_n = 1'b0;
            rem_n   = '0;
            gap_n   = '0;
            done_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state      <= IDLE;
            note_idx   <= '0;
            divisor    <= '0;
            note_valid <= 1'b0;
            remaining  <= '0;
            gap_cnt    <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            note_idx   <= idx_n;
            divisor    <= div_n;
            note_valid <= valid_n;
            remaining  <= rem_n;
            gap_cnt    <= gap_n;
            done       <= done_n;
        end

    assign bus.divisor    = divisor;
    assign bus.note_valid = note_valid;
    assign bus.note_idx   = note_idx;
    assign bus.busy       = state != IDLE;
    assign bus.done       = done;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: random and directed playback checked against a note-list model of the table.
module tb_melody_sequencer;
    localparam int DIV_W = 32, DUR_W = 8, LEN = 25, ADDR_W = 5, GAP = 1;

    typedef struct {int idx; int snd; int sil; logic [31:0] dv; bit bad;} seg_t;

    logic clk = 0, reset = 0;
    int tests = 0, failed = 0;
    logic [31:0] m_div [LEN];
    int m_dur [LEN];
    seg_t segs[$], exp_q[$], cur;
    bit in_seg = 0, exp_done;
    int done_cnt = 0, done_busy_bad = 0;

    melody_sequencer_if #(.DIV_W(DIV_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W)) bus();
    melody_sequencer #(.DIV_W(DIV_W), .DUR_W(DUR_W), .LEN(LEN), .ADDR_W(ADDR_W), .GAP_TICKS(GAP))
        dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    // Tempo ticks every 3..5 clocks, so no tick can land in a LOAD cycle once start is tick-aligned.
    initial begin : tick_gen
        int cnt;
        cnt = 2;
        bus.tick = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.tick = (cnt == 0);
            cnt = (cnt == 0) ? int'($urandom_range(2, 4)) : cnt - 1;
        end
    end

    // Splits playback into per-index segments and counts sounding / silent ticks in each.
    always @(negedge clk) begin
        if (bus.busy) begin
            if (!in_seg || int'(bus.note_idx) != cur.idx) begin
                if (in_seg) segs.push_back(cur);
                cur = '{idx: int'(bus.note_idx), snd: 0, sil: 0, dv: 0, bad: 0};
                in_seg = 1;
            end
            if (bus.divisor != 0) begin
                if (cur.dv != 0 && cur.dv != bus.divisor) cur.bad = 1;
                cur.dv = bus.divisor;
            end
            if (bus.note_valid != (bus.divisor != 0)) cur.bad = 1;
            if (bus.tick) begin
                if (bus.divisor != 0) cur.snd = cur.snd + 1;
                else cur.sil = cur.sil + 1;
            end
        end else if (in_seg) begin
            segs.push_back(cur);
            in_seg = 0;
        end
        if (bus.done) begin
            done_cnt++;
            if (bus.busy) done_busy_bad++;
        end
    end

    function automatic void build_expected(bit lp, int max_segs);
        int i = 0;
        exp_q.delete();
        exp_done = 0;
        while (exp_q.size() < max_segs) begin
            if (m_dur[i] == 0) begin
                exp_q.push_back('{idx: i, snd: 0, sil: 0, dv: 0, bad: 0});
                if (lp && i != 0) begin i = 0; continue; end
                exp_done = 1;
                break;
            end
            exp_q.push_back('{idx: i, snd: (m_div[i] != 0) ? m_dur[i] : 0,
                              sil: (m_div[i] != 0) ? GAP : m_dur[i] + GAP, dv: m_div[i], bad: 0});
            i++;
            if (i == LEN) begin
                if (lp) i = 0;
                else begin exp_done = 1; break; end
            end
        end
    endfunction

    task automatic write_entry(int a, logic [31:0] d, int u);
        @(negedge clk);
        bus.wr_en = 1; bus.wr_addr = ADDR_W'(a); bus.wr_div = d; bus.wr_dur = DUR_W'(u);
        @(posedge clk);
        #1 bus.wr_en = 0;
        if (a < LEN) begin m_div[a] = d; m_dur[a] = u; end
    endtask

    task automatic do_start();
        int c = 0;
        @(negedge clk);
        while (!bus.tick && c < 20) begin @(negedge clk); c++; end
        bus.start = 1;
        @(posedge clk);
        #1 bus.start = 0;
    endtask

    task automatic pulse_stop();
        @(negedge clk) bus.stop = 1;
        @(posedge clk);
        #1 bus.stop = 0;
    endtask

    task automatic wait_idle();
        int c = 0;
        @(negedge clk);
        while (bus.busy && c < 5000) begin @(negedge clk); c++; end
        if (c >= 5000) begin tests++; failed++; $display("FAIL wait_idle: busy=%0b, expected 0 within 5000 cycles", bus.busy); end
        @(negedge clk);
    endtask

    task automatic wait_segs(int n);
        int c = 0;
        while (segs.size() < n && c < 5000) begin @(negedge clk); c++; end
        if (c >= 5000) begin tests++; failed++; $display("FAIL wait_segs: got %0d segments, expected %0d", segs.size(), n); end
    endtask

    task automatic wait_note(int idx, logic [31:0] dv);
        int c = 0;
        @(negedge clk);
        while (!(int'(bus.note_idx) == idx && bus.divisor == dv && bus.note_valid) && c < 5000) begin @(negedge clk); c++; end
        if (c >= 5000) begin tests++; failed++; $display("FAIL wait_note: idx=%0d div=%0d never seen", idx, dv); end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 tests++;
        if ({bus.busy, bus.done, bus.note_valid, bus.note_idx, bus.divisor} !== '0) begin
            failed++; $display("FAIL reset_state: busy=%0b done=%0b valid=%0b idx=%0d div=%0d, expected all 0",
                               bus.busy, bus.done, bus.note_valid, bus.note_idx, bus.divisor);
        end
        @(negedge clk) reset = 1;
        repeat (6) @(posedge clk);
        #1 tests++;
        if (bus.busy !== 0 || bus.done !== 0) begin failed++; $display("FAIL idle_after_reset: busy=%0b done=%0b, expected 0 0", bus.busy, bus.done); end
    endtask

    task automatic test_basic();
        write_entry(0, 22900, 2); write_entry(1, 0, 1); write_entry(2, 20408, 3); write_entry(3, 7, 0);
        bus.loop_en = 0; segs.delete(); done_cnt = 0;
        build_expected(0, 64);
        do_start();
        tests++;
        if (bus.busy !== 1 || bus.divisor !== 0) begin failed++; $display("FAIL start_load: busy=%0b div=%0d, expected 1 0", bus.busy, bus.divisor); end
        @(posedge clk);
        #1 tests++;
        if (bus.divisor !== 22900 || bus.note_valid !== 1 || bus.note_idx !== 0) begin
            failed++; $display("FAIL first_note: div=%0d valid=%0b idx=%0d, expected 22900 1 0", bus.divisor, bus.note_valid, bus.note_idx);
        end
        @(negedge clk) bus.start = 1;
        @(posedge clk);
        #1 bus.start = 0;
        wait_idle();
        tests++;
        if (segs.size() != exp_q.size()) begin failed++; $display("FAIL basic_count: got %0d segments, expected %0d", segs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (i >= segs.size() || segs[i].idx != exp_q[i].idx || segs[i].snd != exp_q[i].snd || segs[i].sil != exp_q[i].sil || segs[i].dv !== exp_q[i].dv || segs[i].bad) begin
                failed++; $display("FAIL basic_seg[%0d]: got idx=%0d div=%0d snd=%0d sil=%0d bad=%0b, expected idx=%0d div=%0d snd=%0d sil=%0d bad=0",
                                   i, segs[i].idx, segs[i].dv, segs[i].snd, segs[i].sil, segs[i].bad, exp_q[i].idx, exp_q[i].dv, exp_q[i].snd, exp_q[i].sil);
            end
        end
        tests++;
        if (done_cnt != 1) begin failed++; $display("FAIL basic_done: got %0d done pulses, expected 1", done_cnt); end
    endtask

    task automatic test_marker0();
        write_entry(0, 5000, 0);
        bus.loop_en = 1; done_cnt = 0;
        do_start();
        tests++;
        if (bus.busy !== 1) begin failed++; $display("FAIL marker0_load: busy=%0b, expected 1", bus.busy); end
        @(posedge clk);
        #1 tests++;
        if (bus.busy !== 0 || bus.done !== 1) begin failed++; $display("FAIL marker0_end: busy=%0b done=%0b, expected 0 1", bus.busy, bus.done); end
        @(posedge clk);
        #1 tests++;
        if (bus.done !== 0 || done_cnt != 1) begin failed++; $display("FAIL marker0_pulse: done=%0b count=%0d, expected 0 1", bus.done, done_cnt); end
        bus.loop_en = 0;
    endtask

    task automatic test_stop_start();
        write_entry(0, 22900, 2);
        done_cnt = 0;
        do_start();
        wait_note(0, 22900);
        bus.start = 1; bus.stop = 1;
        @(posedge clk);
        #1 bus.start = 0; bus.stop = 0;
        tests++;
        if ({bus.busy, bus.note_valid, bus.note_idx, bus.divisor} !== '0) begin
            failed++; $display("FAIL stop_idle: busy=%0b valid=%0b idx=%0d div=%0d, expected all 0", bus.busy, bus.note_valid, bus.note_idx, bus.divisor);
        end
        repeat (5) @(posedge clk);
        #1 tests++;
        if (done_cnt != 0 || bus.busy !== 0) begin failed++; $display("FAIL stop_no_done: done count=%0d busy=%0b, expected 0 0", done_cnt, bus.busy); end
        do_start();
        @(posedge clk);
        #1 tests++;
        if (bus.note_idx !== 0 || bus.divisor !== 22900) begin failed++; $display("FAIL restart: idx=%0d div=%0d, expected 0 22900", bus.note_idx, bus.divisor); end
        wait_idle();
    endtask

    task automatic test_loop_full();
        bit ok = 1;
        for (int i = 0; i < LEN; i++) write_entry(i, $urandom_range(1000, 60000), 1);
        bus.loop_en = 1; segs.delete(); done_cnt = 0;
        do_start();
        wait_segs(26);
        for (int i = 0; i < 26; i++) if (segs[i].idx != i % LEN) ok = 0;
        tests++;
        if (!ok || done_cnt != 0) begin failed++; $display("FAIL loop_order: ok=%0b done count=%0d, expected 1 0", ok, done_cnt); end
        wait_note(LEN - 1, m_div[LEN-1]);
        bus.loop_en = 0;
        wait_idle();
        tests++;
        if (done_cnt != 1) begin failed++; $display("FAIL loop_exit_done: got %0d done pulses, expected 1", done_cnt); end
        tests++;
        if (segs.size() != 2 * LEN || segs[segs.size()-1].idx != LEN - 1) begin
            failed++; $display("FAIL loop_exit_count: got %0d segments last idx=%0d, expected %0d and %0d", segs.size(), segs[segs.size()-1].idx, 2 * LEN, LEN - 1);
        end
    endtask

    task automatic test_write_during_play();
        write_entry(0, 15000, 1); write_entry(1, 12876, 2); write_entry(2, 0, 0);
        bus.loop_en = 1; segs.delete(); done_cnt = 0;
        do_start();
        wait_note(1, 12876);
        write_entry(1, 11472, 2);
        write_entry(27, 999, 0);
        wait_segs(5);
        pulse_stop();
        wait_idle();
        bus.loop_en = 0;
        tests++;
        if (segs[1].idx != 1 || segs[1].dv !== 12876 || segs[1].snd != 2 || segs[1].bad) begin
            failed++; $display("FAIL write_current: got idx=%0d div=%0d snd=%0d, expected 1 12876 2", segs[1].idx, segs[1].dv, segs[1].snd);
        end
        tests++;
        if (segs[2].idx != 2 || segs[2].snd != 0 || segs[2].sil != 0 || segs[3].idx != 0 || segs[3].dv !== 15000) begin
            failed++; $display("FAIL marker_wrap: got idx=%0d then idx=%0d div=%0d, expected 2 then 0 15000", segs[2].idx, segs[3].idx, segs[3].dv);
        end
        tests++;
        if (segs[4].idx != 1 || segs[4].dv !== 11472 || segs[4].snd != 2) begin
            failed++; $display("FAIL write_next: got idx=%0d div=%0d snd=%0d, expected 1 11472 2", segs[4].idx, segs[4].dv, segs[4].snd);
        end
        tests++;
        if (done_cnt != 0) begin failed++; $display("FAIL write_no_done: got %0d done pulses, expected 0", done_cnt); end
    endtask

    task automatic test_async_reset();
        write_entry(0, 22900, 2); write_entry(1, 0, 1); write_entry(2, 20408, 3); write_entry(3, 0, 0);
        bus.loop_en = 0;
        do_start();
        wait_note(2, 20408);
        #2 reset = 0;
        #1 tests++;
        if ({bus.busy, bus.done, bus.note_valid, bus.note_idx, bus.divisor} !== '0) begin
            failed++; $display("FAIL async_reset: busy=%0b done=%0b valid=%0b idx=%0d div=%0d, expected all 0",
                               bus.busy, bus.done, bus.note_valid, bus.note_idx, bus.divisor);
        end
        @(negedge clk) reset = 1;
        @(posedge clk);
        #1 segs.delete(); done_cnt = 0;
        build_expected(0, 64);
        do_start();
        wait_idle();
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (i >= segs.size() || segs[i].idx != exp_q[i].idx || segs[i].snd != exp_q[i].snd || segs[i].sil != exp_q[i].sil || segs[i].dv !== exp_q[i].dv || segs[i].bad) begin
                failed++; $display("FAIL replay_seg[%0d]: got idx=%0d div=%0d snd=%0d sil=%0d, expected idx=%0d div=%0d snd=%0d sil=%0d",
                                   i, segs[i].idx, segs[i].dv, segs[i].snd, segs[i].sil, exp_q[i].idx, exp_q[i].dv, exp_q[i].snd, exp_q[i].sil);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int len = $urandom_range(2, 10);
            bit lp = it[0];
            int exp_dn;
            for (int i = 0; i < len; i++)
                write_entry(i, ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1000, 60000)), $urandom_range(1, 3));
            write_entry(len, $urandom, 0);
            build_expected(lp, lp ? 14 : 64);
            exp_dn = lp ? 0 : int'(exp_done);
            segs.delete(); done_cnt = 0; bus.loop_en = lp;
            do_start();
            if (lp) begin wait_segs(exp_q.size()); pulse_stop(); end
            wait_idle();
            if (!lp) begin
                tests++;
                if (segs.size() != exp_q.size()) begin failed++; $display("FAIL rand%0d_count: got %0d segments, expected %0d", it, segs.size(), exp_q.size()); end
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++;
                if (i >= segs.size() || segs[i].idx != exp_q[i].idx || segs[i].snd != exp_q[i].snd || segs[i].sil != exp_q[i].sil || segs[i].dv !== exp_q[i].dv || segs[i].bad) begin
                    failed++; $display("FAIL rand%0d_seg[%0d]: got idx=%0d div=%0d snd=%0d sil=%0d bad=%0b, expected idx=%0d div=%0d snd=%0d sil=%0d bad=0",
                                       it, i, segs[i].idx, segs[i].dv, segs[i].snd, segs[i].sil, segs[i].bad, exp_q[i].idx, exp_q[i].dv, exp_q[i].snd, exp_q[i].sil);
                end
            end
            tests++;
            if (done_cnt != exp_dn) begin failed++; $display("FAIL rand%0d_done: got %0d done pulses, expected %0d", it, done_cnt, exp_dn); end
        end
        tests++;
        if (done_busy_bad != 0) begin failed++; $display("FAIL done_busy: done seen with busy high %0d times, expected 0", done_busy_bad); end
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.loop_en = 0; bus.wr_en = 0;
        bus.wr_addr = '0; bus.wr_div = '0; bus.wr_dur = '0;
        for (int i = 0; i < LEN; i++) begin m_div[i] = 0; m_dur[i] = 0; end
        test_reset();
        test_basic();
        test_marker0();
        test_stop_start();
        test_loop_full();
        test_write_during_play();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end
endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Programmable note sequencer for the buzzer/tone path: holds a table of up to LEN entries (tone divisor + duration in tempo ticks), and on start plays them in order. Presents each entry's divisor to the downstream square-wave divider for exactly its duration, separated by an optional silent articulation gap. Supports rests, early end markers, loop or one-shot mode, and abort. Sits between the table-loading logic and the tone divider; tempo comes from an external one-cycle `tick` strobe.

## Interface
- DIV_W, 32, divisor width (half-period count of the tone divider)
- DUR_W, 8, duration field width, in ticks
- LEN, 25, table depth (entries 0..LEN-1)
- ADDR_W, 5, index width; must satisfy 2^ADDR_W ≥ LEN
- GAP_TICKS, 1, silent ticks inserted after every entry; 0 disables the gap
- clk  in  1  system clock, single clock domain
- reset  in  1  asynchronous, active-low reset
- tick  in  1  tempo strobe, one cycle wide
- start  in  1  begin playback from entry 0
- stop  in  1  abort playback
- loop_en  in  1  1 = wrap to entry 0 after the last entry; 0 = one-shot
- wr_en  in  1  table write strobe
- wr_addr  in  ADDR_W  table write index
- wr_div  in  DIV_W  divisor to write; 0 marks a rest
- wr_dur  in  DUR_W  duration to write; 0 marks end of melody
- divisor  out  DIV_W  current tone divisor; 0 when silent
- note_valid  out  1  tone enable (1 only while a non-rest entry is sounding)
- note_idx  out  ADDR_W  index of the entry being played
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on natural end of a one-shot melody

## Operation
- Table: LEN × (DIV_W + DUR_W) registers. Not cleared by reset. Writes are accepted in any state. Writes with wr_addr ≥ LEN are ignored.
- States: IDLE, LOAD, PLAY, GAP.
- IDLE: divisor = 0, note_valid = 0, busy = 0. On start, with stop low: note_idx ← 0, go to LOAD.
- LOAD (one cycle): read entry[note_idx].
  - If dur = 0, the melody ends (see end handling).
  - Otherwise latch divisor ← div, remaining ← dur, note_valid ← (div ≠ 0), go to PLAY.
- PLAY: every tick decrements remaining. On the tick where remaining = 1:
  - if GAP_TICKS > 0, go to GAP with note_valid ← 0 and divisor ← 0;
  - otherwise advance.
- GAP: counts GAP_TICKS ticks, then advances.
- Advance:
  - If note_idx < LEN-1: note_idx + 1, go to LOAD.
  - If note_idx = LEN-1: end handling.
- End handling:
  - If loop_en (sampled at that cycle) is 1 and the end was not an end marker at index 0: note_idx ← 0, go to LOAD.
  - Otherwise: done pulses, go to IDLE.
  - An end marker at index 0 always terminates, which prevents a zero-length infinite loop.
  - An end marker at an index > 0 wraps when loop_en = 1.
- A write to the entry currently playing does not affect that note. It takes effect the next time that entry is loaded.

## Timing
- Reset: state IDLE, divisor = 0, note_valid = 0, note_idx = 0, busy = 0, done = 0, all counters 0.
- All outputs are registered.
- start sampled at edge N: busy = 1 from N+1 (LOAD), divisor and note_valid valid from N+2 (PLAY).
- Ticks are ignored in IDLE and LOAD, including a tick coincident with start.
- A note of dur D holds for exactly D ticks. PLAY exits on the edge that samples the D-th tick.
- Advance to LOAD takes one cycle, so consecutive notes are separated by 1 clk (GAP_TICKS = 0) or by GAP_TICKS ticks + 1 clk.
- done: asserted for exactly one cycle, coincident with the first IDLE cycle. busy = 0 in that same cycle.
- stop, in any state: next cycle IDLE, divisor = 0, note_valid = 0, note_idx = 0, no done pulse.
- stop and start in the same cycle: stop wins. start while busy is ignored.
- Asynchronous reset mid-playback: outputs go to their reset values immediately, without waiting for a clock edge.

## Test plan
- Load entries 0..2 = (22900,2), (0,1), (20408,3) and entry 3 dur = 0; GAP_TICKS = 1; loop_en = 0; start; tick every 4 clk.
  - Required: divisor 22900 with note_valid = 1 for 2 ticks; gap; rest with divisor 0 and note_valid = 0 for 1 tick; gap; 20408 for 3 ticks; gap; done pulse once; busy falls.
- Full table of LEN = 25 entries with dur = 1, loop_en = 1.
  - Required: note_idx sequence 0..24, then 0 again, with no done pulse.
  - Then clear loop_en while entry 24 plays: done pulses after entry 24.
- Entry 0 dur = 0, loop_en = 1, start.
  - Required: busy for exactly 1 cycle (LOAD), done pulses, return to IDLE.
- Mid-note stop asserted together with start.
  - Required: IDLE next cycle, divisor = 0, no done pulse.
  - A subsequent start restarts at note_idx 0.
- Write entry 1 = (11472,2) while entry 1 = (12876,2) is playing.
  - Required: the current note stays 12876; the next loop plays 11472.
  - A write to wr_addr 27 changes nothing.
- Assert reset low during PLAY.
  - Required: all outputs go to reset values asynchronously.
  - Table contents survive: a replay after reset reproduces the loaded melody.
